// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and edge-detect board buttons and switches
// Buttons become one-cycle press pulses; the switch bank is accepted only as a whole stable vector.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnL_raw,
    input  logic        btnR_raw,
    input  logic [15:0] switch_raw,
    output logic        buttonL,
    output logic        buttonR,
    output logic [15:0] switch
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       r_btn_sync1;
    logic [1:0]       r_btn_s;
    logic [1:0]       r_stable;
    logic [1:0]       r_stable_d;
    logic [1:0]       r_pulse;
    logic [CNT_W-1:0] r_cnt [2];

    logic [15:0]      r_sw_sync1;
    logic [15:0]      r_sw_s;
    logic [15:0]      r_sw_prev;
    logic [CNT_W-1:0] r_sw_cnt;
    logic [15:0]      r_switch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_sync1 <= '0;
            r_btn_s     <= '0;
            r_stable    <= '0;
            r_stable_d  <= '0;
            r_pulse     <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_btn_sync1 <= {btnR_raw, btnL_raw};
            r_btn_s     <= r_btn_sync1;
            // Any cycle agreeing with the accepted level restarts the count.
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_btn_s[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            r_stable_d <= r_stable;
            r_pulse    <= r_stable & ~r_stable_d;
        end
    end

    // The switch vector counts as one unit; the counter parks at its max while stable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sw_sync1 <= '0;
            r_sw_s     <= '0;
            r_sw_prev  <= '0;
            r_sw_cnt   <= '0;
            r_switch   <= '0;
        end else begin
            r_sw_sync1 <= switch_raw;
            r_sw_s     <= r_sw_sync1;
            r_sw_prev  <= r_sw_s;
            if (r_sw_s != r_sw_prev) begin
                r_sw_cnt <= '0;
            end else if (r_sw_cnt != CNT_MAX) begin
                r_sw_cnt <= r_sw_cnt + CNT_ONE;
            end else begin
                r_switch <= r_sw_prev;
            end
        end
    end

    assign buttonL = r_pulse[0];
    assign buttonR = r_pulse[1];
    assign switch  = r_switch;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with DEBOUNCE_CYCLES = 4
module tb_button_conditioner;

    localparam int N = 4;

    typedef struct {
        logic        l;
        logic        r;
        logic [15:0] sw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        btnL_raw;
    logic        btnR_raw;
    logic [15:0] switch_raw;
    logic        buttonL;
    logic        buttonR;
    logic [15:0] switch;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .btnL_raw   (btnL_raw),
        .btnR_raw   (btnR_raw),
        .switch_raw (switch_raw),
        .buttonL    (buttonL),
        .buttonR    (buttonR),
        .switch     (switch)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next rising edge, queue what should be visible after it, then step past it.
    task automatic drive_edge(input logic rst, input logic l, input logic r, input logic [15:0] sw,
                              input logic el, input logic er, input logic [15:0] esw);
        exp_t x;
        @(negedge clk);
        reset      = rst;
        btnL_raw   = l;
        btnR_raw   = r;
        switch_raw = sw;
        x.l = el;
        x.r = er;
        x.sw = esw;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int e = 0; e < 3; e++) begin
            drive_edge(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL reset_hold e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
        for (int e = 0; e < 12; e++) begin
            drive_edge(1'b1, 1'b1, 1'b1, 16'hFFFF, e == 6, e == 6, (e >= 6) ? 16'hFFFF : 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL reset_release e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
        for (int e = 0; e < 12; e++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, (e >= 6) ? 16'h0000 : 16'hFFFF);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL reset_settle e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_clean_press();
        exp_t x;
        for (int e = 0; e < 35; e++) begin
            drive_edge(1'b1, e < 20, 1'b0, 16'h0000, e == 6, 1'b0, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL clean_press e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_min_press();
        exp_t x;
        for (int e = 0; e < 20; e++) begin
            drive_edge(1'b1, e < N, 1'b0, 16'h0000, e == 6, 1'b0, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL min_press e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_short_glitch();
        exp_t x;
        for (int e = 0; e < 15; e++) begin
            drive_edge(1'b1, e < N - 1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL short_glitch e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t x;
        logic [4:0] pat;
        logic       r;
        pat = 5'b01101;
        for (int e = 0; e < 33; e++) begin
            r = (e < 5) ? pat[e] : (e <= 20);
            drive_edge(1'b1, 1'b0, r, 16'h0000, 1'b0, e == 11, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL bounce e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t x;
        for (int e = 0; e < 22; e++) begin
            drive_edge(1'b1, e < 10, e < 10, 16'h0000, e == 6, e == 6, 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL simultaneous e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_switch_settle();
        exp_t x;
        logic [15:0] sw;
        for (int e = 0; e < 16; e++) begin
            sw = (e < 2) ? 16'hA5A5 : (e == 2) ? 16'hA5A4 : 16'h5A5A;
            drive_edge(1'b1, 1'b0, 1'b0, sw, 1'b0, 1'b0, (e >= 9) ? 16'h5A5A : 16'h0000);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL switch_settle e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        for (int e = 0; e < 32; e++) begin
            drive_edge(!(e == 3 || e == 4), e < 21, 1'b0, 16'h5A5A, e == 11, 1'b0,
                       (e >= 3 && e < 11) ? 16'h0000 : 16'h5A5A);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL reset_mid e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    task automatic test_reset_pulse();
        exp_t x;
        for (int e = 0; e < 26; e++) begin
            drive_edge(e != 6, e < 18, 1'b0, 16'h5A5A, e == 13, 1'b0,
                       (e >= 6 && e < 13) ? 16'h0000 : 16'h5A5A);
            x = sb.pop_front();
            checks++;
            if ({buttonL, buttonR, switch} !== {x.l, x.r, x.sw}) begin
                errors++;
                $display("FAIL reset_pulse e=%0d got L=%b R=%b sw=%h exp L=%b R=%b sw=%h", e, buttonL, buttonR, switch, x.l, x.r, x.sw);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        btnL_raw   = 1'b0;
        btnR_raw   = 1'b0;
        switch_raw = 16'h0000;
        test_reset();
        test_clean_press();
        test_min_press();
        test_short_glitch();
        test_bounce();
        test_simultaneous();
        test_switch_settle();
        test_reset_mid();
        test_reset_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner between the board's raw push-buttons/slide switches and the CPU-side I/O port block. Synchronises all asynchronous board inputs into `clk`, debounces the two buttons and the 16-bit switch bank, and turns each debounced button press into a single-cycle pulse. Its `buttonL`, `buttonR` and `switch` outputs drive the same-named inputs of the I/O port block directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a level is accepted (10 ms at 100 MHz). Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width. Derived; do not override.

Ports:
- `clk` in 1: the single system clock.
- `reset` in 1: synchronous, active-low. 0 = reset, sampled on `clk` rising edge.
- `btnL_raw` in 1: raw left button (LED-commit button), asynchronous, bouncy.
- `btnR_raw` in 1: raw right button (switch-capture button), asynchronous, bouncy.
- `switch_raw` in 16: raw slide switches, asynchronous, bouncy.
- `buttonL` out 1: one-cycle pulse per debounced press of `btnL_raw`.
- `buttonR` out 1: one-cycle pulse per debounced press of `btnR_raw`.
- `switch` out 16: debounced, synchronised switch value.

## Operation
- **Synchronisers.** Each raw input passes through a 2-flop synchroniser: `btnL_raw`, `btnR_raw`, and all 16 `switch_raw` bits. The second flop is the synced value `s`.
- **Button debouncer (one instance per button).**
  - State: `stable` (1 bit), counter `cnt` (`CNT_W` bits).
  - If `s == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Net effect: `stable` changes only after exactly `DEBOUNCE_CYCLES` consecutive mismatching cycles. Any single matching cycle restarts the count.
- **Pulse generator.**
  - `stable_d <= stable`.
  - Registered output: `button* <= stable & ~stable_d`.
  - Pulse fires on press (rising edge) only. Release produces no pulse. One pulse per press regardless of hold length.
- **Switch debouncer (16-bit vector as one unit).**
  - State: `sw_prev <= s_sw` every cycle, plus counter `sw_cnt`.
  - If `s_sw != sw_prev`: `sw_cnt <= 0`.
  - Else if `sw_cnt != DEBOUNCE_CYCLES-1`: `sw_cnt <= sw_cnt + 1`.
  - Else (`sw_cnt == DEBOUNCE_CYCLES-1`): `switch <= sw_prev`.
  - `switch` updates only once the whole vector has been unchanged for `DEBOUNCE_CYCLES` cycles. While stable, `sw_cnt` saturates at `DEBOUNCE_CYCLES-1`.
- **Independence.** Both buttons and the switch path are fully independent. Simultaneous presses produce pulses in the same cycle when their timing is identical.

## Timing
- **Reset.** While `reset == 0` at an edge, the following are cleared to 0: all synchroniser flops, `stable`, `stable_d`, `cnt`, `sw_prev`, `sw_cnt`. Outputs: `buttonL = 0`, `buttonR = 0`, `switch = 16'h0000`.
- **Press latency.** Let `N = DEBOUNCE_CYCLES`, and let raw rise be first sampled at edge 0.
  - Edge 1: `s = 1`.
  - Edge N+1: `stable = 1`.
  - Edge N+2: `button*` goes high, for exactly one cycle.
- **Glitch rejection.** A raw high lasting fewer than N cycles after synchronisation produces no pulse. A low glitch during a held press shorter than N cycles produces no second pulse.
- **Release.** `stable` falls N cycles after the synced low. No output activity.
- **Switch latency.** After `switch_raw` settles at edge 0, `switch` shows the new value after edge N+2. Any bit change restarts the wait.
- **Reset mid-debounce.** Count is discarded. A button still held when `reset` returns to 1 is treated as a new press: it gets the full N+2-edge latency and yields one pulse.
- **Reset while pulse high.** Pulse is cleared at that edge.

## Test plan
1. **Reset values.** Apply `reset = 0` for 3 cycles with all raw inputs at 1 → `buttonL = buttonR = 0` and `switch = 0` throughout. Release reset with `DEBOUNCE_CYCLES = 4` → `buttonL` and `buttonR` each pulse exactly once, at edge 6 after release; `switch = 16'hFFFF` at edge 6.
2. **Clean press.** `N = 4`, `btnL_raw` high for 20 cycles → exactly one `buttonL` pulse, 1 cycle wide, at edge 6. No pulse on release.
3. **Bounce.** `btnR_raw` toggles 1,0,1,1,0 over cycles, then held high → no pulse during bounce. One pulse N+2 edges after the final rise.
4. **Short glitch.** `btnL_raw` high for 3 cycles with `N = 4` → no pulse, `stable` stays 0.
5. **Switch settle.** `switch_raw = 16'hA5A5`, a bit flips at cycle 2, final value `16'h5A5A` → `switch` goes directly from 0 to `16'h5A5A` 6 edges after the last change, with no intermediate `16'hA5A5`.
6. **Reset mid-count.** Hold `btnL_raw` high, assert reset at edge 3, release at edge 5 → no pulse before reset. One pulse 6 edges after release.
